// File: rtl/mem_arbiter.sv
// Single-port work RAM arbiter between CPU bus and video fetch; CPU has default priority,
// bounded video wait. Ready is combinational, read data arrives 2 cycles after ready.
module mem_arbiter #(
  parameter int P_addr_bits    = 15,
  parameter int P_data_bits    = 8,
  parameter int P_vid_max_wait = 4
) (
  input  logic                   I_clock,
  input  logic                   I_reset,
  input  logic [P_addr_bits-1:0] I_cpu_addr,
  input  logic                   I_cpu_rden,
  input  logic                   I_cpu_wren,
  input  logic [P_data_bits-1:0] I_cpu_data,
  output logic                   O_cpu_ready,
  output logic                   O_cpu_valid,
  output logic [P_data_bits-1:0] O_cpu_data,
  input  logic [P_addr_bits-1:0] I_vid_addr,
  input  logic                   I_vid_rden,
  output logic                   O_vid_ready,
  output logic                   O_vid_valid,
  output logic [P_data_bits-1:0] O_vid_data,
  output logic [P_addr_bits-1:0] O_mem_addr,
  output logic                   O_mem_rden,
  output logic                   O_mem_wren,
  output logic [P_data_bits-1:0] O_mem_data,
  input  logic [P_data_bits-1:0] I_mem_data
);

  localparam int LP_CW = (P_vid_max_wait > 0) ? $clog2(P_vid_max_wait + 1) : 1;
  localparam logic [LP_CW-1:0] LP_MAX = LP_CW'(P_vid_max_wait);

  logic                   w_cpu_req;
  logic                   w_vid_due;
  logic                   w_cpu_win;
  logic                   w_vid_win;

  logic [LP_CW-1:0]       r_wait_cnt;
  logic [P_addr_bits-1:0] r_mem_addr;
  logic [P_data_bits-1:0] r_mem_data;
  logic                   r_mem_rden;
  logic                   r_mem_wren;
  logic                   r_t1_vid;
  logic                   r_t2_cpu;
  logic                   r_t2_vid;
  logic [P_data_bits-1:0] r_cpu_data;
  logic [P_data_bits-1:0] r_vid_data;

  assign w_cpu_req = I_cpu_rden | I_cpu_wren;

  // With a zero wait budget video is always due, so it takes every contended cycle.
  generate
    if (P_vid_max_wait == 0) begin : g_vid_abs
      assign w_vid_due = 1'b1;
    end else begin : g_vid_bounded
      assign w_vid_due = (r_wait_cnt >= LP_MAX);
    end
  endgenerate

  always_comb begin
    w_vid_win = 1'b0;
    w_cpu_win = 1'b0;
    if (I_reset) begin
      if (I_vid_rden && (!w_cpu_req || w_vid_due)) begin
        w_vid_win = 1'b1;
      end else if (w_cpu_req) begin
        w_cpu_win = 1'b1;
      end
    end
  end

  assign O_cpu_ready = w_cpu_win;
  assign O_vid_ready = w_vid_win;

  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_wait_cnt <= '0;
    end else if (!I_vid_rden || w_vid_win) begin
      r_wait_cnt <= '0;
    end else if (w_cpu_win && (r_wait_cnt < LP_MAX)) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  // Command stage: address/data hold through idle cycles, strobes do not.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_rden <= 1'b0;
      r_mem_wren <= 1'b0;
      r_t1_vid   <= 1'b0;
    end else begin
      r_mem_rden <= w_vid_win | (w_cpu_win & ~I_cpu_wren);
      r_mem_wren <= w_cpu_win & I_cpu_wren;
      r_t1_vid   <= w_vid_win;
      if (w_vid_win) begin
        r_mem_addr <= I_vid_addr;
      end else if (w_cpu_win) begin
        r_mem_addr <= I_cpu_addr;
        if (I_cpu_wren) begin
          r_mem_data <= I_cpu_data;
        end
      end
    end
  end

  // Return stage: tag lines up with the cycle the RAM drives its read data.
  always_ff @(posedge I_clock or negedge I_reset) begin
    if (!I_reset) begin
      r_t2_cpu   <= 1'b0;
      r_t2_vid   <= 1'b0;
      r_cpu_data <= '0;
      r_vid_data <= '0;
    end else begin
      r_t2_cpu <= r_mem_rden & ~r_t1_vid;
      r_t2_vid <= r_mem_rden & r_t1_vid;
      if (r_t2_cpu) begin
        r_cpu_data <= I_mem_data;
      end
      if (r_t2_vid) begin
        r_vid_data <= I_mem_data;
      end
    end
  end

  assign O_mem_addr  = r_mem_addr;
  assign O_mem_data  = r_mem_data;
  assign O_mem_rden  = r_mem_rden;
  assign O_mem_wren  = r_mem_wren;

  assign O_cpu_valid = r_t2_cpu;
  assign O_vid_valid = r_t2_vid;
  assign O_cpu_data  = r_t2_cpu ? I_mem_data : r_cpu_data;
  assign O_vid_data  = r_t2_vid ? I_mem_data : r_vid_data;

endmodule
